btn_conditioner: RTL and testbench
==================================

// Module: btn_conditioner
// PURPOSE
//  Parametrised push-button front end for the puzzle top: NUM_BTN raw async buttons in,
//  clean debounced levels, 1-cycle press/release pulses, optional per-channel auto-repeat,
//  and a buffered valid/ready key-event stream for the game FSM. Sits between board pins and
//  game logic; replaces ad-hoc per-button edge logic.
// PARAMETERS
//  NUM_BTN       5   number of button channels (1..16)
//  DEBOUNCE_CYC  16  consecutive stable cycles required before a level change is accepted (>=2)
//  REPEAT_DELAY  64  cycles from press pulse to first repeat pulse (>=2)
//  REPEAT_RATE   16  cycles between subsequent repeat pulses (>=2)
// PORTS
//  clk          in   1              system clock
//  rst          in   1              asynchronous, active-high reset
//  btn_raw      in   NUM_BTN        raw button pins, async, 1 = pressed
//  repeat_en    in   NUM_BTN        per-channel auto-repeat enable (sync to clk)
//  btn_level    out  NUM_BTN        debounced level
//  btn_press    out  NUM_BTN        1-cycle pulse on accepted 0->1
//  btn_release  out  NUM_BTN        1-cycle pulse on accepted 1->0
//  btn_repeat   out  NUM_BTN        1-cycle auto-repeat pulse
//  evt_valid    out  1              key event pending
//  evt_idx      out  $clog2(NUM_BTN) channel of presented event (lowest pending index)
//  evt_ready    in   1              consumer accepts event when evt_valid & evt_ready
//  evt_ovf      out  1              sticky: event dropped because channel already pending
// BEHAVIOUR
//  - Reset: all outputs 0; sync FFs, stable levels, counters, pending bits cleared; FSMs IDLE.
//    Reset mid-debounce/mid-repeat aborts; a still-held button re-qualifies as a fresh press.
//  - Sync: 2-FF synchroniser per channel. Debounce counter counts cycles sync != stable; any
//    cycle sync == stable clears it. On the edge the count reaches DEBOUNCE_CYC, stable flips,
//    counter clears. Glitches shorter than DEBOUNCE_CYC never propagate.
//  - btn_press/btn_release registered: high exactly one cycle, the cycle after stable flips.
//    Latency raw edge -> pulse = DEBOUNCE_CYC+3 clock edges.
//  - Repeat FSM per channel: IDLE -> DELAY on press pulse if repeat_en; DELAY counts
//    REPEAT_DELAY cycles, emits btn_repeat, -> REPEAT; REPEAT emits btn_repeat every
//    REPEAT_RATE cycles. Any state -> IDLE (no pulse) on release pulse or repeat_en low
//    (next cycle). press and repeat never pulse in the same cycle on a channel.
//  - Event buffer: pending[i] set by btn_press[i] | btn_repeat[i]. evt_valid = |pending;
//    evt_idx = lowest set index, stable while evt_valid & !evt_ready. Handshake clears that bit.
//    Same-cycle set+clear of one bit leaves it set (new event kept). Set while already pending
//    and not being cleared -> event dropped, evt_ovf sticks 1 until reset.
//  - Releases do not generate events. Counters sized $clog2(max param)+1; no wrap in normal use.
// STRUCTURE
//  - btn_pkg: typedef enum {IDLE, DELAY, REPEAT} rpt_state_t; cnt_width() function.
//  - Sub-module btn_channel (sync + debounce + repeat FSM), generate-instantiated NUM_BTN times;
//    top level holds only pending register, priority encoder, overflow flag.
// TESTING (bench params: NUM_BTN=5, DEBOUNCE_CYC=4, REPEAT_DELAY=8, REPEAT_RATE=3)
//  1 rst=1 with btn_raw=5'b11111 -> all outputs 0; rst=0 -> btn_press=5'b11111 7 edges later.
//  2 btn_raw[2] 3-cycle high glitch -> no btn_level/press change; 6-cycle high -> one press[2],
//    btn_level[2]=1, evt_valid=1, evt_idx=2.
//  3 repeat_en[0]=1, hold btn[0] 30 cycles, evt_ready=1 -> press at t, repeat at t+8,t+11,t+14..;
//    release -> btn_release[0] pulse, no further repeats.
//  4 press btn[3] and btn[1] same cycle, evt_ready=0 4 cycles then 1 -> evt_idx=1 then 3,
//    evt_valid drops after 2nd handshake.
//  5 evt_ready=0, repeat_en[4]=1, hold btn[4] past 2nd repeat -> evt_ovf=1, stays 1.
//  6 assert rst during DELAY of a held repeating button -> no pulses; after rst=0 fresh press
//    after 7 edges, repeat restarts from DELAY.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and sizing helpers for the push-button conditioner.
package btn_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDelay,
    StRepeat
  } rpt_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // One spare bit over the largest terminal count so counters never wrap in normal use.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return $clog2(max_val) + 1;
  endfunction

endpackage

// File: rtl/btn_conditioner_channel.sv
// One button channel: 2-FF synchroniser, debounce, edge pulses and auto-repeat FSM.
module btn_channel
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 16,
  parameter int unsigned REPEAT_DELAY = 64,
  parameter int unsigned REPEAT_RATE  = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn_raw,
  input  logic i_repeat_en,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_repeat
);

  localparam int unsigned MaxCyc = max_u(DEBOUNCE_CYC, max_u(REPEAT_DELAY, REPEAT_RATE));
  localparam int unsigned CW     = cnt_width(MaxCyc);

  localparam logic [CW-1:0] DebLast   = CW'(DEBOUNCE_CYC - 1);
  localparam logic [CW-1:0] DelayLast = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RateLast  = CW'(REPEAT_RATE - 1);

  logic          r_sync1, r_sync2;
  logic          r_stable, r_stable_q;
  logic [CW-1:0] r_dcnt;
  logic          r_press, r_release;

  rpt_state_t    r_state;
  logic [CW-1:0] r_rcnt;
  logic          r_repeat;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_stable   <= 1'b0;
      r_stable_q <= 1'b0;
      r_dcnt     <= '0;
      r_press    <= 1'b0;
      r_release  <= 1'b0;
    end else begin
      r_sync1    <= i_btn_raw;
      r_sync2    <= r_sync1;
      r_stable_q <= r_stable;
      // Pulses come one cycle after the stable level flips.
      r_press    <= r_stable & ~r_stable_q;
      r_release  <= ~r_stable & r_stable_q;
      if (r_sync2 == r_stable) begin
        r_dcnt <= '0;
      end else if (r_dcnt == DebLast) begin
        r_stable <= r_sync2;
        r_dcnt   <= '0;
      end else begin
        r_dcnt <= r_dcnt + 1'b1;
      end
    end
  end

  // r_rcnt counts cycles since the last press/repeat pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= StIdle;
      r_rcnt   <= '0;
      r_repeat <= 1'b0;
    end else begin
      r_repeat <= 1'b0;
      case (r_state)
        StIdle: begin
          if (r_press && i_repeat_en) begin
            r_state <= StDelay;
            r_rcnt  <= CW'(1);
          end
        end
        StDelay: begin
          if (r_release || !i_repeat_en) begin
            r_state <= StIdle;
            r_rcnt  <= '0;
          end else if (r_rcnt == DelayLast) begin
            r_state  <= StRepeat;
            r_rcnt   <= '0;
            r_repeat <= 1'b1;
          end else begin
            r_rcnt <= r_rcnt + 1'b1;
          end
        end
        StRepeat: begin
          if (r_release || !i_repeat_en) begin
            r_state <= StIdle;
            r_rcnt  <= '0;
          end else if (r_rcnt == RateLast) begin
            r_rcnt   <= '0;
            r_repeat <= 1'b1;
          end else begin
            r_rcnt <= r_rcnt + 1'b1;
          end
        end
        default: begin
          r_state <= StIdle;
          r_rcnt  <= '0;
        end
      endcase
    end
  end

  assign o_level   = r_stable;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_repeat  = r_repeat;

endmodule

// File: rtl/btn_conditioner.sv
// Push-button front end: per-channel conditioning plus a lowest-index-first key-event buffer.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned NUM_BTN      = 5,
  parameter int unsigned DEBOUNCE_CYC = 16,
  parameter int unsigned REPEAT_DELAY = 64,
  parameter int unsigned REPEAT_RATE  = 16,
  localparam int unsigned IW          = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_BTN-1:0] i_btn_raw,
  input  logic [NUM_BTN-1:0] i_repeat_en,
  output logic [NUM_BTN-1:0] o_btn_level,
  output logic [NUM_BTN-1:0] o_btn_press,
  output logic [NUM_BTN-1:0] o_btn_release,
  output logic [NUM_BTN-1:0] o_btn_repeat,
  output logic               o_evt_valid,
  output logic [IW-1:0]      o_evt_idx,
  input  logic               i_evt_ready,
  output logic               o_evt_ovf
);

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
    ) u_channel (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_btn_raw  (i_btn_raw[g]),
      .i_repeat_en(i_repeat_en[g]),
      .o_level    (o_btn_level[g]),
      .o_press    (o_btn_press[g]),
      .o_release  (o_btn_release[g]),
      .o_repeat   (o_btn_repeat[g])
    );
  end

  logic [NUM_BTN-1:0] r_pending;
  logic               r_ovf;
  logic               r_hold;
  logic [IW-1:0]      r_hold_idx;

  logic [IW-1:0]      w_low_idx;
  logic [NUM_BTN-1:0] w_set;
  logic [NUM_BTN-1:0] w_clr;
  logic               w_hs;

  always_comb begin
    w_low_idx = '0;
    for (int i = int'(NUM_BTN) - 1; i >= 0; i--) begin
      if (r_pending[i]) w_low_idx = IW'(i);
    end
  end

  // A stalled event keeps its index even if a lower channel becomes pending.
  assign o_evt_idx   = r_hold ? r_hold_idx : w_low_idx;
  assign o_evt_valid = |r_pending;
  assign o_evt_ovf   = r_ovf;
  assign w_hs        = o_evt_valid & i_evt_ready;
  assign w_set       = o_btn_press | o_btn_repeat;

  always_comb begin
    w_clr = '0;
    for (int i = 0; i < int'(NUM_BTN); i++) begin
      w_clr[i] = w_hs && (o_evt_idx == IW'(i));
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pending  <= '0;
      r_ovf      <= 1'b0;
      r_hold     <= 1'b0;
      r_hold_idx <= '0;
    end else begin
      r_pending  <= (r_pending & ~w_clr) | w_set;
      if (|(w_set & r_pending & ~w_clr)) r_ovf <= 1'b1;
      r_hold     <= o_evt_valid & ~i_evt_ready;
      r_hold_idx <= o_evt_idx;
    end
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with short debounce/repeat timings.
module tb_btn_conditioner;

  logic       clk;
  logic       rst;
  logic [4:0] raw;
  logic [4:0] rpt_en;
  logic [4:0] level, press, rel, rpt;
  logic       valid, ready, ovf;
  logic [2:0] idx;

  int n_tests = 0;
  int n_fail  = 0;

  btn_conditioner #(
    .NUM_BTN     (5),
    .DEBOUNCE_CYC(4),
    .REPEAT_DELAY(8),
    .REPEAT_RATE (3)
  ) u_dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_btn_raw    (raw),
    .i_repeat_en  (rpt_en),
    .o_btn_level  (level),
    .o_btn_press  (press),
    .o_btn_release(rel),
    .o_btn_repeat (rpt),
    .o_evt_valid  (valid),
    .o_evt_idx    (idx),
    .i_evt_ready  (ready),
    .o_evt_ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [4:0] acc;
    int         cnt;
    int         at;
    rst    = 1'b1;
    raw    = 5'b11111;
    rpt_en = 5'b00000;
    ready  = 1'b0;

    // 1: reset with all buttons held, then fresh presses
    repeat (3) tick();
    check_eq("rst_level", 32'(level), 32'h0);
    check_eq("rst_press", 32'(press), 32'h0);
    check_eq("rst_release", 32'(rel), 32'h0);
    check_eq("rst_repeat", 32'(rpt), 32'h0);
    check_eq("rst_valid", 32'(valid), 32'h0);
    check_eq("rst_ovf", 32'(ovf), 32'h0);
    rst = 1'b0;
    repeat (6) tick();
    check_eq("t1_no_early_press", 32'(press), 32'h0);
    tick();
    check_eq("t1_press_all", 32'(press), 32'h1f);
    check_eq("t1_level_all", 32'(level), 32'h1f);
    tick();
    check_eq("t1_press_single", 32'(press), 32'h0);
    check_eq("t1_valid", 32'(valid), 32'h1);
    check_eq("t1_idx", 32'(idx), 32'h0);
    raw   = 5'b00000;
    ready = 1'b1;
    repeat (7) tick();
    check_eq("t1_release_all", 32'(rel), 32'h1f);
    repeat (5) tick();
    check_eq("t1_drained", 32'(valid), 32'h0);
    check_eq("t1_level_low", 32'(level), 32'h0);
    check_eq("t1_no_ovf", 32'(ovf), 32'h0);

    // 2: short glitch filtered, longer pulse accepted
    ready = 1'b0;
    acc   = '0;
    raw[2] = 1'b1;
    repeat (3) begin tick(); acc |= press | level; end
    raw[2] = 1'b0;
    repeat (10) begin tick(); acc |= press | level; end
    check_eq("t2_glitch", 32'(acc), 32'h0);
    raw[2] = 1'b1;
    cnt = 0;
    at  = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 6) raw[2] = 1'b0;
      if (press[2]) begin cnt++; at = k; end
      if (k == 7) check_eq("t2_level", 32'(level[2]), 32'h1);
    end
    check_eq("t2_press_count", 32'(cnt), 32'd1);
    check_eq("t2_press_time", 32'(at), 32'd7);
    check_eq("t2_valid", 32'(valid), 32'h1);
    check_eq("t2_idx", 32'(idx), 32'd2);
    ready = 1'b1;
    repeat (12) tick();
    check_eq("t2_drained", 32'(valid), 32'h0);

    // 3: auto-repeat on channel 0, then release stops it
    rpt_en[0] = 1'b1;
    raw[0]    = 1'b1;
    repeat (7) tick();
    check_eq("t3_press", 32'(press[0]), 32'h1);
    for (int k = 1; k <= 35; k++) begin
      tick();
      check_eq($sformatf("t3_repeat_k%0d", k), 32'(rpt[0]),
               32'((k >= 8) && (k <= 26) && ((k - 8) % 3 == 0)));
      if (k > 20) check_eq($sformatf("t3_release_k%0d", k), 32'(rel[0]), 32'(k == 27));
      if (k == 20) raw[0] = 1'b0;
    end
    rpt_en[0] = 1'b0;
    repeat (3) tick();
    check_eq("t3_drained", 32'(valid), 32'h0);
    check_eq("t3_no_ovf", 32'(ovf), 32'h0);

    // 4: simultaneous presses served lowest index first
    ready  = 1'b0;
    raw[3] = 1'b1;
    raw[1] = 1'b1;
    repeat (7) tick();
    check_eq("t4_press", 32'(press), 32'h0a);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq("t4_valid_stall", 32'(valid), 32'h1);
      check_eq("t4_idx_first", 32'(idx), 32'd1);
    end
    ready = 1'b1;
    tick();
    check_eq("t4_valid_second", 32'(valid), 32'h1);
    check_eq("t4_idx_second", 32'(idx), 32'd3);
    tick();
    check_eq("t4_valid_drop", 32'(valid), 32'h0);
    raw = 5'b00000;
    repeat (10) tick();

    // 5: repeat while still pending overflows, sticky
    ready     = 1'b0;
    rpt_en[4] = 1'b1;
    raw[4]    = 1'b1;
    repeat (7) tick();
    check_eq("t5_press", 32'(press[4]), 32'h1);
    for (int k = 1; k <= 13; k++) begin
      tick();
      if (k == 8) check_eq("t5_repeat1", 32'(rpt[4]), 32'h1);
      if (k == 8) check_eq("t5_ovf_before", 32'(ovf), 32'h0);
      if (k == 9) check_eq("t5_ovf_set", 32'(ovf), 32'h1);
      if (k == 11) check_eq("t5_repeat2", 32'(rpt[4]), 32'h1);
    end
    check_eq("t5_idx", 32'(idx), 32'd4);
    raw[4]    = 1'b0;
    rpt_en[4] = 1'b0;
    ready     = 1'b1;
    repeat (12) tick();
    check_eq("t5_ovf_sticky", 32'(ovf), 32'h1);
    check_eq("t5_drained", 32'(valid), 32'h0);

    // 6: reset during repeat delay, held button re-qualifies
    rpt_en[0] = 1'b1;
    raw[0]    = 1'b1;
    repeat (7) tick();
    check_eq("t6_press", 32'(press[0]), 32'h1);
    repeat (3) tick();
    rst = 1'b1;
    acc = '0;
    repeat (4) begin tick(); acc |= press | rel | rpt | level; end
    check_eq("t6_rst_quiet", 32'(acc), 32'h0);
    check_eq("t6_rst_ovf", 32'(ovf), 32'h0);
    check_eq("t6_rst_valid", 32'(valid), 32'h0);
    rst = 1'b0;
    repeat (6) tick();
    check_eq("t6_no_early_press", 32'(press), 32'h0);
    tick();
    check_eq("t6_press_again", 32'(press), 32'h01);
    for (int k = 1; k <= 11; k++) begin
      tick();
      check_eq($sformatf("t6_repeat_k%0d", k), 32'(rpt[0]), 32'((k == 8) || (k == 11)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
